// File: rtl/mpc_div_div_36s_14ns_21_seq.sv
// mpc_div_div_36s_14ns_21_seq
//   Iterative restoring radix-2 divider: signed 36-bit dividend / unsigned
//   14-bit divisor -> signed 21-bit quotient plus signed remainder.
//   One quotient bit per enabled clock, valid/ready handshakes on both sides.
//   Optional feature macro: MPC_DIV_SAT_EN
//     defined   : overflowing quotients saturate to the QUOT_W signed limits
//     undefined : overflowing quotients wrap (two's complement truncation)
//   ovf is flagged in both builds; divide-by-zero always saturates.
module mpc_div_div_36s_14ns_21_seq #(
  parameter int DIVIDEND_W = 36,
  parameter int DIVISOR_W  = 14,
  parameter int QUOT_W     = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     dout,
  output logic [DIVISOR_W:0]    rem,
  output logic                  div0,
  output logic                  ovf
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  // Largest quotient magnitude that still fits, per sign.
  localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'((64'd1 << (QUOT_W-1)) - 64'd1);
  localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(64'd1 << (QUOT_W-1));
  localparam logic [QUOT_W-1:0]     QMAX    = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0]     QMIN    = {1'b1, {(QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t                state;
  logic [DIVIDEND_W-1:0] dq;    // dividend bits shift out of the MSB, quotient bits enter at the LSB
  logic [DIVISOR_W-1:0]  dvsr;
  logic [DIVISOR_W:0]    pr;    // partial remainder, unsigned
  logic                  neg;
  logic [CNT_W-1:0]      cnt;

  logic [DIVIDEND_W-1:0] mag;
  logic [DIVISOR_W+1:0]  pr_sh;
  logic [DIVISOR_W+1:0]  pr_sub;
  logic                  ge;
  logic [DIVISOR_W:0]    pr_nxt;
  logic                  zero;
  logic                  ovf_c;
  logic [QUOT_W-1:0]     qtrunc;
  logic [QUOT_W-1:0]     qwrap;
  logic [QUOT_W-1:0]     dout_c;
  logic [DIVISOR_W:0]    rem_c;

  // Dividend magnitude. The unsigned DIVIDEND_W-bit negation of the most
  // negative input yields 2^(DIVIDEND_W-1), which is exact as an unsigned value.
  always_comb begin
    mag = din0[DIVIDEND_W-1] ? (~din0 + DIVIDEND_W'(1)) : din0;
  end

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    pr_sh  = {pr, dq[DIVIDEND_W-1]};
    pr_sub = pr_sh - {2'b00, dvsr};
    ge     = (pr_sh >= {2'b00, dvsr});
    pr_nxt = ge ? pr_sub[DIVISOR_W:0] : pr_sh[DIVISOR_W:0];
  end

  // Result shaping: sign application, range check, saturation or wrap.
  always_comb begin
    zero   = (dvsr == '0);
    ovf_c  = neg ? (dq > NEG_LIM) : (dq > POS_LIM);
    qtrunc = dq[QUOT_W-1:0];
    qwrap  = neg ? (-qtrunc) : qtrunc;   // equals the signed quotient mod 2^QUOT_W
    rem_c  = neg ? (-pr) : pr;
    if (zero)
      dout_c = neg ? QMIN : QMAX;
`ifdef MPC_DIV_SAT_EN
    else if (ovf_c)
      dout_c = neg ? QMIN : QMAX;
`endif
    else
      dout_c = qwrap;
  end

  // Control FSM and datapath registers; everything freezes when ce=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      rem       <= '0;
      div0      <= 1'b0;
      ovf       <= 1'b0;
      dq        <= '0;
      dvsr      <= '0;
      pr        <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            dq       <= mag;
            dvsr     <= din1;
            neg      <= din0[DIVIDEND_W-1];
            pr       <= '0;
            cnt      <= CNT_W'(DIVIDEND_W-1);
            in_ready <= 1'b0;
            state    <= CALC;
          end else begin
            in_ready <= 1'b1;
          end
        end
        CALC: begin
          dq <= {dq[DIVIDEND_W-2:0], ge};
          pr <= pr_nxt;
          if (cnt == '0) state <= FIN;
          else           cnt   <= cnt - CNT_W'(1);
        end
        FIN: begin
          dout      <= dout_c;
          rem       <= zero ? '0 : rem_c;
          div0      <= zero;
          ovf       <= zero ? 1'b0 : ovf_c;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpc_div_div_36s_14ns_21_seq.sv
// Self-checking bench for mpc_div_div_36s_14ns_21_seq: directed cases,
// stall/backpressure/reset scenarios and random operands against an
// arithmetic reference model.
module tb_mpc_div_div_36s_14ns_21_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [35:0] din0 = '0;
  logic [13:0] din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [20:0] dout;
  logic [14:0] rem;
  logic        div0;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  mpc_div_div_36s_14ns_21_seq dut (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .rem(rem), .div0(div0), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic, truncation toward zero.
  task automatic model(input longint a, input int b,
                       output logic [20:0] q, output logic [14:0] r,
                       output logic d0, output logic ov);
    longint aa, qa, ra, qs, rs;
    d0 = (b == 0);
    ov = 1'b0;
    if (b == 0) begin
      q = (a >= 0) ? 21'h0FFFFF : 21'h100000;
      r = '0;
    end else begin
      aa = (a < 0) ? -a : a;
      qa = aa / b;
      ra = aa % b;
      qs = (a < 0) ? -qa : qa;
      rs = (a < 0) ? -ra : ra;
      ov = (qs > 1048575) || (qs < -1048576);
      q  = qs[20:0];
`ifdef MPC_DIV_SAT_EN
      if (ov) q = (qs > 0) ? 21'h0FFFFF : 21'h100000;
`endif
      r = rs[14:0];
    end
  endtask

  // One full transaction: accept, optional ce stall, result check, optional backpressure.
  task automatic run(input longint a, input int b, input int st, input int sl, input int hold);
    logic [20:0] eq;
    logic [14:0] er;
    logic        ed, eo;
    int          n;
    model(a, b, eq, er, ed, eo);
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("in_ready_idle", in_ready, 1);
    din0 = a[35:0];
    din1 = b[13:0];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("in_ready_busy", in_ready, 0);
    n = 0;
    while (!out_valid && n < 300) begin
      ce = !(n >= st && n < st + sl);
      tick();
      n++;
    end
    ce = 1'b1;
    chk("latency", n, 37 + sl);
    chk("dout", dout, eq);
    chk("rem", rem, er);
    chk("div0", div0, ed);
    chk("ovf", ovf, eo);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_dout", dout, eq);
      chk("hold_rem", rem, er);
      chk("hold_flags", {div0, ovf}, {ed, eo});
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consumed_valid", out_valid, 0);
    chk("ready_after_consume", in_ready, 1);
  endtask

  initial begin
    int unsigned r1, r2;
    int          m, b, n;
    logic [35:0] ar;
    longint      a;
    logic        seen;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {dout, rem, div0, ovf}, 0);
    reset = 1'b1;
    tick();
    chk("rst_release_ready", in_ready, 1);

    // Directed cases
    run(1000, 7, 0, 0, 0);
    run(-1000, 7, 0, 0, 0);
    run(7, 1000, 0, 0, 0);
    run(5, 0, 0, 0, 0);
    run(-5, 0, 0, 0, 0);
    run(64'sd1 << 30, 1, 0, 0, 0);
    run(-(64'sd1 << 35), 1, 0, 0, 0);
    run((64'sd1 << 35) - 1, 16383, 0, 0, 0);
    run(-(64'sd1 << 35), 16383, 0, 0, 0);
    run(-1048576, 1, 0, 0, 0);
    run(1048576, 1, 0, 0, 0);
    // Backpressure
    run(1000, 7, 0, 0, 10);
    // ce stall mid-CALC
    run(123456789, 321, 10, 5, 0);

    // Reset pulsed mid-CALC discards the result
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    din0 = 36'd99999; din1 = 14'd13; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_outputs", {dout, rem, div0, ovf}, 0);
    chk("midrst_in_ready", in_ready, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_release_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin tick(); if (out_valid) seen = 1'b1; end
    chk("midrst_no_valid", seen, 0);

    // Random operands
    for (int i = 0; i < 30; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      m  = $urandom_range(0, 3);
      ar = {r1[3:0], r2};
      if (m == 1) ar = {{16{r1[31]}}, r2[19:0]};
      if (m == 2) ar = {{12{r1[31]}}, r2[23:0]};
      b = $urandom_range(0, 16383);
      if (m == 3) b = $urandom_range(1, 15);
      if (r1[10:8] == 3'd0) b = 0;
      a = longint'($signed(ar));
      run(a, b, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
